// File: rtl/galaksija_kbd_pkg.sv
// Shared definitions for the Galaksija serial keyboard: key indices, FSM states
// and the ASCII-to-matrix mapping used when a received byte is queued.
package galaksija_kbd_pkg;

    localparam int KEY_SHIFT = 53;
    localparam int KEY_ENTER = 48;
    localparam int KEY_BREAK = 49;
    localparam int KEY_LEFT  = 29;
    localparam int KEY_SPACE = 31;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LEAD,
        PRESS,
        GAP
    } kbd_state_e;

    typedef struct packed {
        logic       valid;
        logic       shift;
        logic [5:0] index;
    } key_map_t;

    // Letters share keys regardless of case; the Galaksija has no lowercase.
    function automatic key_map_t mapAscii(input logic [7:0] c);
        key_map_t m;
        m.valid = 1'b0;
        m.shift = 1'b0;
        m.index = 6'd0;
        if (c >= 8'h41 && c <= 8'h5A) begin
            m.valid = 1'b1;
            m.index = 6'(c - 8'h40);
        end else if (c >= 8'h61 && c <= 8'h7A) begin
            m.valid = 1'b1;
            m.index = 6'(c - 8'h60);
        end else if (c >= 8'h30 && c <= 8'h39) begin
            m.valid = 1'b1;
            m.index = 6'(c - 8'h10);
        end else begin
            m.valid = 1'b1;
            case (c)
                8'h20:         m.index = 6'(KEY_SPACE);
                8'h0A, 8'h0D: m.index = 6'(KEY_ENTER);
                8'h08, 8'h7F: m.index = 6'(KEY_LEFT);
                8'h1B:         m.index = 6'(KEY_BREAK);
                8'h3B:         m.index = 6'd42;
                8'h3A:         m.index = 6'd43;
                8'h2C:         m.index = 6'd44;
                8'h3D:         m.index = 6'd45;
                8'h2E:         m.index = 6'd46;
                8'h2F:         m.index = 6'd47;
                8'h5F: begin m.shift = 1'b1; m.index = 6'd32; end
                8'h21: begin m.shift = 1'b1; m.index = 6'd33; end
                8'h22: begin m.shift = 1'b1; m.index = 6'd34; end
                8'h23: begin m.shift = 1'b1; m.index = 6'd35; end
                8'h24: begin m.shift = 1'b1; m.index = 6'd36; end
                8'h25: begin m.shift = 1'b1; m.index = 6'd37; end
                8'h26: begin m.shift = 1'b1; m.index = 6'd38; end
                8'h5C: begin m.shift = 1'b1; m.index = 6'd39; end
                8'h28: begin m.shift = 1'b1; m.index = 6'd40; end
                8'h29: begin m.shift = 1'b1; m.index = 6'd41; end
                8'h2B: begin m.shift = 1'b1; m.index = 6'd42; end
                8'h2A: begin m.shift = 1'b1; m.index = 6'd43; end
                8'h3C: begin m.shift = 1'b1; m.index = 6'd44; end
                8'h2D: begin m.shift = 1'b1; m.index = 6'd45; end
                8'h3E: begin m.shift = 1'b1; m.index = 6'd46; end
                8'h3F: begin m.shift = 1'b1; m.index = 6'd47; end
                default:       m.valid = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/serial_key_matrix_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign dout_o  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/serial_key_matrix.sv
// Serial keyboard front end: queues mapped UART characters and replays them as
// timed key presses on the Galaksija key matrix read by the CPU.
module serial_key_matrix
    import galaksija_kbd_pkg::*;
#(
    parameter int NUM_KEYS          = 64,
    parameter int FIFO_DEPTH        = 16,
    parameter int HOLD_CYCLES       = 1000000,
    parameter int GAP_CYCLES        = 500000,
    parameter int SHIFT_LEAD_CYCLES = 250000,
    localparam int KAW              = $clog2(NUM_KEYS)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    input  logic           clear_all,
    input  logic           key_rd,
    input  logic [KAW-1:0] key_addr,
    output logic [7:0]     key_out,
    output logic           busy,
    output logic           overflow
);

    localparam int MAXA = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXC = (MAXA > SHIFT_LEAD_CYCLES) ? MAXA : SHIFT_LEAD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int FW   = KAW + 1;

    kbd_state_e          state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic [KAW-1:0]      pendIdx_q, pendIdx_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          keyOut_q;

    key_map_t            rxMap;
    logic                pushReq;
    logic                popReq;
    logic [FW-1:0]       fifoDout;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                headShift;
    logic [KAW-1:0]      headIdx;
    logic                readHit;

    assign rxMap     = mapAscii(rx_data);
    assign pushReq   = rx_valid && rxMap.valid && !clear_all;
    assign headShift = fifoDout[KAW];
    assign headIdx   = fifoDout[KAW-1:0];

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (clear_all),
        .push_i  (pushReq),
        .pop_i   (popReq),
        .din_i   ({rxMap.shift, KAW'(rxMap.index)}),
        .dout_o  (fifoDout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Each state reloads the shared down-counter with N-1 on entry so it lasts N cycles.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        keys_d     = keys_q;
        pendIdx_d  = pendIdx_q;
        overflow_d = overflow_q;
        popReq     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    popReq    = 1'b1;
                    pendIdx_d = headIdx;
                    if (headShift) begin
                        keys_d[KEY_SHIFT] = 1'b1;
                        state_d           = SHIFT_LEAD;
                        count_d           = CW'(SHIFT_LEAD_CYCLES - 1);
                    end else begin
                        keys_d[headIdx] = 1'b1;
                        state_d         = PRESS;
                        count_d         = CW'(HOLD_CYCLES - 1);
                    end
                end
            end
            SHIFT_LEAD: begin
                if (count_q == '0) begin
                    keys_d[pendIdx_q] = 1'b1;
                    state_d           = PRESS;
                    count_d           = CW'(HOLD_CYCLES - 1);
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            PRESS: begin
                if (count_q == '0) begin
                    keys_d  = '0;
                    state_d = GAP;
                    count_d = CW'(GAP_CYCLES - 1);
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            GAP: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                keys_d  = '0;
            end
        endcase

        if (rx_valid && rxMap.valid && fifoFull && !popReq) begin
            overflow_d = 1'b1;
        end

        if (clear_all) begin
            state_d    = IDLE;
            count_d    = '0;
            keys_d     = '0;
            overflow_d = 1'b0;
            popReq     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            keys_q     <= '0;
            pendIdx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            keys_q     <= keys_d;
            pendIdx_q  <= pendIdx_d;
            overflow_q <= overflow_d;
        end
    end

    // Matrix reads are active-low: a pressed key pulls bit 0 low.
    assign readHit = (int'(key_addr) < NUM_KEYS) && keys_q[key_addr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            keyOut_q <= 8'hFF;
        end else if (key_rd) begin
            keyOut_q <= readHit ? 8'hFE : 8'hFF;
        end
    end

    assign key_out  = keyOut_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_serial_key_matrix.sv
// Bench for serial_key_matrix: directed scenarios plus random traffic, checked
// every cycle against a schedule-based model of key press intervals.
module tb_serial_key_matrix;

    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int LEAD  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clear_all;
    logic       key_rd;
    logic [5:0] key_addr;
    logic [7:0] key_out;
    logic       busy;
    logic       overflow;

    always #5 clk = ~clk;

    serial_key_matrix #(
        .NUM_KEYS          (64),
        .FIFO_DEPTH        (DEPTH),
        .HOLD_CYCLES       (HOLD),
        .GAP_CYCLES        (GAP),
        .SHIFT_LEAD_CYCLES (LEAD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .clear_all (clear_all),
        .key_rd    (key_rd),
        .key_addr  (key_addr),
        .key_out   (key_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    int testCount = 0;
    int failCount = 0;
    int edgeNum   = -1;

    typedef struct {
        bit sh;
        int idx;
    } entry_t;

    // The model tracks only the pending queue and the edge numbers at which the
    // current character's SHIFT, its key, the release and the return to idle happen.
    entry_t     modelQ[$];
    int         freeAt   = -1;
    int         shStart  = 0;
    int         keyStart = 0;
    int         relAt    = 0;
    bit         curSh    = 0;
    int         curIdx   = 0;
    bit         expOvf   = 0;
    logic [7:0] expKeyOut = 8'hFF;

    function automatic bit mapChar(input logic [7:0] c, output bit sh, output int idx);
        string shifted = "_!\"#$%&\\()+*<->?";
        string plain   = ";:,=./";
        int ci = int'(c);
        sh  = 0;
        idx = 0;
        if (ci >= 65 && ci <= 90)  begin idx = ci - 64; return 1; end
        if (ci >= 97 && ci <= 122) begin idx = ci - 96; return 1; end
        if (ci >= 48 && ci <= 57)  begin idx = 32 + ci - 48; return 1; end
        if (ci == 32)              begin idx = 31; return 1; end
        if (ci == 10 || ci == 13)  begin idx = 48; return 1; end
        if (ci == 8 || ci == 127)  begin idx = 29; return 1; end
        if (ci == 27)              begin idx = 49; return 1; end
        for (int i = 0; i < plain.len(); i++)
            if (int'(plain[i]) == ci) begin idx = 42 + i; return 1; end
        for (int i = 0; i < shifted.len(); i++)
            if (int'(shifted[i]) == ci) begin sh = 1; idx = 32 + i; return 1; end
        return 0;
    endfunction

    function automatic bit [63:0] keysAfter(input int n);
        bit [63:0] k = '0;
        if (curSh && n >= shStart && n < relAt) k[53] = 1'b1;
        if (n >= keyStart && n < relAt) k[curIdx] = 1'b1;
        return k;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, edgeNum);
        end
    endtask

    // One clock edge of stimulus; addr < 0 means no key read this cycle.
    task automatic applyStimulus(input bit rxv, input logic [7:0] data, input bit clr,
                                 input bit rstn, input int addr);
        bit [63:0] prevKeys;
        bit        sh;
        int        idx;
        bit        mapped;
        entry_t    e;
        rx_valid  = rxv;
        rx_data   = data;
        clear_all = clr;
        reset_n   = rstn;
        key_rd    = (addr >= 0);
        key_addr  = (addr >= 0) ? 6'(addr) : 6'd0;
        @(posedge clk);
        edgeNum++;
        prevKeys = keysAfter(edgeNum - 1);
        if (!rstn) expKeyOut = 8'hFF;
        else if (addr >= 0) expKeyOut = prevKeys[addr] ? 8'hFE : 8'hFF;
        if (!rstn || clr) begin
            modelQ.delete();
            freeAt   = edgeNum;
            relAt    = edgeNum;
            shStart  = edgeNum;
            keyStart = edgeNum;
            expOvf   = 0;
        end else begin
            if (edgeNum > freeAt && modelQ.size() > 0) begin
                e        = modelQ.pop_front();
                curSh    = e.sh;
                curIdx   = e.idx;
                shStart  = edgeNum;
                keyStart = edgeNum + (e.sh ? LEAD : 0);
                relAt    = keyStart + HOLD;
                freeAt   = relAt + GAP;
            end
            mapped = mapChar(data, sh, idx);
            if (rxv && mapped) begin
                if (modelQ.size() < DEPTH) begin
                    e.sh  = sh;
                    e.idx = idx;
                    modelQ.push_back(e);
                end else begin
                    expOvf = 1;
                end
            end
        end
        #1;
        checkOutput("key_out", key_out, expKeyOut);
        checkOutput("busy", {7'd0, busy}, {7'd0, (edgeNum < freeAt) || (modelQ.size() > 0)});
        checkOutput("overflow", {7'd0, overflow}, {7'd0, expOvf});
    endtask

    task automatic idleCycles(input int n, input int addr);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, addr);
    endtask

    initial begin
        int         presses;
        logic [7:0] prevOut;
        int         addr;
        logic [7:0] data;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1);
        checkOutput("reset key_out", key_out, 8'hFF);
        checkOutput("reset busy", {7'd0, busy}, 8'h00);
        checkOutput("reset overflow", {7'd0, overflow}, 8'h00);

        // Plain key: pressed E1..E8, released at E9, idle again at E13.
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 1);
        idleCycles(5, 1);
        checkOutput("A pressed", key_out, 8'hFE);
        idleCycles(5, 1);
        checkOutput("A released", key_out, 8'hFF);
        idleCycles(2, 1);
        checkOutput("A busy E12", {7'd0, busy}, 8'h01);
        idleCycles(1, 1);
        checkOutput("A busy E13", {7'd0, busy}, 8'h00);

        // Shifted key: SHIFT from E1, key 33 from E3, both released at E11.
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b1, 53);
        idleCycles(2, 53);
        checkOutput("shift lead", key_out, 8'hFE);
        idleCycles(3, 33);
        checkOutput("bang key", key_out, 8'hFE);
        idleCycles(2, 53);
        checkOutput("shift held", key_out, 8'hFE);
        idleCycles(5, 33);
        checkOutput("bang released", key_out, 8'hFF);
        idleCycles(4, 53);

        // Six back-to-back bytes into a 4-deep FIFO: one dropped, five presses.
        presses = 0;
        prevOut = key_out;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'h31, 1'b0, 1'b1, 33);
            if (key_out == 8'hFE && prevOut == 8'hFF) presses++;
            prevOut = key_out;
        end
        checkOutput("overflow set", {7'd0, overflow}, 8'h01);
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 33);
            if (key_out == 8'hFE && prevOut == 8'hFF) presses++;
            prevOut = key_out;
        end
        checkOutput("press count", 8'(presses), 8'd5);

        // clear_all mid-press with two bytes queued and a byte arriving.
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b1, 34);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 34);
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b1, 34);
        idleCycles(2, 34);
        applyStimulus(1'b1, 8'h35, 1'b1, 1'b1, 34);
        checkOutput("clear busy", {7'd0, busy}, 8'h00);
        checkOutput("clear overflow", {7'd0, overflow}, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 34);
        checkOutput("clear keys", key_out, 8'hFF);
        idleCycles(30, 35);

        // Unmapped byte is ignored; only 'z' (key 26) follows.
        applyStimulus(1'b1, 8'h7E, 1'b0, 1'b1, 26);
        applyStimulus(1'b1, 8'h7A, 1'b0, 1'b1, 26);
        checkOutput("unmapped overflow", {7'd0, overflow}, 8'h00);
        idleCycles(4, 26);
        checkOutput("z pressed", key_out, 8'hFE);
        idleCycles(16, 26);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 63);
        checkOutput("addr 63", key_out, 8'hFF);

        // Reset during SHIFT_LEAD.
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b1, 53);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 53);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 53);
        checkOutput("reset mid lead key_out", key_out, 8'hFF);
        checkOutput("reset mid lead busy", {7'd0, busy}, 8'h00);
        idleCycles(3, 53);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0:       addr = -1;
                1, 2:    addr = 53;
                3, 4, 5: addr = curIdx;
                default: addr = int'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 1) == 0) data = 8'($urandom_range(0, 255));
            else data = 8'($urandom_range(32, 63));
            applyStimulus($urandom_range(0, 9) == 0, data,
                          $urandom_range(0, 199) == 0, $urandom_range(0, 499) != 0, addr);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_key_matrix.md
Name: serial_key_matrix

Overview:
- Parametrised successor to the top-level serial-keyboard decoder: turns UART ASCII bytes into the Galaksija 64-key matrix seen by the CPU at 0x2000-0x27FF.
- Adds a character FIFO (paste/queued typing), timed press/release so keys auto-release, and SHIFT-lead sequencing.
- Sits between uart_rx and the CPU data-in mux; owns the key_out read path.

Parameters:
- NUM_KEYS, 64, matrix size; key index width KAW = clog2(NUM_KEYS).
- FIFO_DEPTH, 16, queued characters; power of two, >= 2.
- HOLD_CYCLES, 1000000, clk cycles a key is held pressed (40 ms at 25 MHz).
- GAP_CYCLES, 500000, clk cycles with all keys released between characters.
- SHIFT_LEAD_CYCLES, 250000, clk cycles SHIFT alone is pressed before a shifted key.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- rx_data  in  8  received ASCII byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- clear_all  in  1  flush FIFO and release all keys (driven from the uart "starting" rising edge).
- key_rd  in  1  CPU read strobe for the key region.
- key_addr  in  KAW  key index (CPU addr[5:0]).
- key_out  out  8  registered read data.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- overflow  out  1  sticky; a mapped byte was dropped because the FIFO was full.

Behaviour:
- Reset: FIFO empty, all keys released, FSM IDLE, key_out = 8'hFF, busy = 0, overflow = 0.
- Enqueue: at an edge with rx_valid = 1, rx_data is mapped to {shift, index}.
  - Unmapped bytes are dropped silently; overflow is not set.
  - A mapped byte arriving when the FIFO is full is dropped and sets overflow, unless a pop occurs in the same cycle; then the push is accepted.
- Mapping:
  - A-Z and a-z -> 1..26.
  - 0-9 -> 32..41.
  - space -> 31.
  - LF/CR -> 48.
  - BS/DEL -> 29.
  - ESC -> 49.
  - Unshifted: ; -> 42, : -> 43, comma -> 44, = -> 45, . -> 46, / -> 47.
  - Shifted (index plus SHIFT = 53): _ ! " # $ % & \ ( ) + * < - > ? -> 32..47 in that order.
- FSM states: IDLE, SHIFT_LEAD, PRESS, GAP.
  - IDLE: if the FIFO is non-empty, pop at this edge.
    - Shifted entry: set key 53 and go to SHIFT_LEAD.
    - Unshifted entry: set key[index] and go to PRESS.
    - Key bits change at the pop edge.
  - SHIFT_LEAD: after SHIFT_LEAD_CYCLES cycles, set key[index] and go to PRESS.
  - PRESS: after HOLD_CYCLES cycles, release all keys and go to GAP.
  - GAP: after GAP_CYCLES cycles, go to IDLE.
  - A single down-counter is loaded on each state entry; a state lasts exactly N cycles.
- Latency: rx_valid at edge E0 into an empty FIFO while IDLE gives the key pressed from edge E1 (the pop edge).
- Read: at an edge with key_rd = 1, key_out <= 8'hFE if the key at key_addr is pressed, else 8'hFF. An index >= NUM_KEYS reads 8'hFF. Without key_rd, key_out holds its value.
- clear_all: at the next edge, FIFO empty, keys released, FSM IDLE, counter cleared, overflow cleared. It has priority over a simultaneous rx_valid, whose byte is discarded.
- Reset mid-operation behaves identically to clear_all and also sets key_out = 8'hFF.
- FIFO pointers are KAWF+1 bits with wrap; full/empty are derived from the MSB compare.
- busy is combinational from state and FIFO count.

Decomposition:
- Package galaksija_kbd_pkg holds:
  - the key index constants (KEY_SHIFT = 53, KEY_ENTER = 48, KEY_BREAK = 49, KEY_LEFT = 29, KEY_SPACE = 31);
  - the state enum;
  - the ASCII-to-{valid, shift, index} mapping function.
- One sub-module: sync_fifo (parametrised width and depth, push/pop/full/empty, same-cycle push+pop when full).

Test Plan:
- Use small parameters: HOLD = 8, GAP = 4, LEAD = 2, FIFO_DEPTH = 4.
- rx "A": key 1 is set at E1, and a read of addr 1 during the 8 PRESS cycles gives 8'hFE. At E9 all keys are released and addr 1 reads 8'hFF. busy falls at E13.
- rx "!": key 53 is set at E1, key 33 is added at E3, both release at E11, and a read of addr 53 mid-press gives 8'hFE.
- 6 back-to-back "1" bytes while IDLE: 1 byte is popped immediately and 4 are queued, so 1 is dropped and overflow = 1. Exactly 5 presses of key 33 occur, each separated by 4 released cycles.
- rx 0x7E (unmapped) then "z": 0x7E is ignored with overflow = 0, and only key 26 is pressed.
- clear_all asserted during PRESS with 2 bytes queued, plus rx_valid in the same cycle: at the next edge all keys read 8'hFF, busy = 0, overflow = 0, and no further presses occur.
- Read of addr 63 while key 63 is unmapped gives 8'hFF. Asserting reset_n = 0 mid-SHIFT_LEAD gives key_out = 8'hFF and state IDLE after one edge.
